// File: rtl/smart_home_pkg.sv
// Shared types and constants for the smart-home input front end:
// conversion FSM states, sensor frame geometry and temperature range.
package smart_home_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_UPDATE
  } conv_state_t;

  localparam int TEMP_MAX   = 31;
  localparam int FRAME_BITS = 9;
  localparam int TEMP_W     = 5;

  // Clamp the full 8-bit reading so values above the range pin at TEMP_MAX.
  function automatic logic [TEMP_W-1:0] saturate_temp(input logic [7:0] data);
    if (data > 8'(TEMP_MAX)) return TEMP_W'(TEMP_MAX);
    return data[TEMP_W-1:0];
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioning: two-flop synchronizer, stability counter and a
// single-cycle pulse on each accepted press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic button
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_meta;
  logic             sync_q;
  logic             level;
  logic [CNT_W-1:0] stable_cnt;
  logic             accept;

  assign accept = (sync_q != level) && (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= button_raw;
      sync_q    <= sync_meta;
    end
  end

  // A sample matching the current level restarts the stability count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level      <= 1'b0;
      stable_cnt <= '0;
      button     <= 1'b0;
    end else begin
      button <= accept && sync_q;
      if (sync_q == level) begin
        stable_cnt <= '0;
      end else if (accept) begin
        level      <= sync_q;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/smart_home_input.sv
// Smart-home input front end: debounced push-button plus a periodic serial
// temperature-sensor reader with saturation and malformed-frame flagging.
module smart_home_input
  import smart_home_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCLK_DIV        = 2,
  parameter int SAMPLE_INTERVAL = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button_raw,
  input  logic              sensor_sdo,
  output logic              sensor_cs_n,
  output logic              sensor_sclk,
  output logic              button,
  output logic [TEMP_W-1:0] temperature,
  output logic              temp_valid,
  output logic              sensor_err
);

  localparam int HALF_PERIODS = 2 * FRAME_BITS;
  localparam int IDLE_W       = $clog2(SAMPLE_INTERVAL + 1);
  localparam int DIV_W        = $clog2(SCLK_DIV + 1);
  localparam int HALF_W       = $clog2(HALF_PERIODS + 1);

  conv_state_t           state;
  conv_state_t           next_state;
  logic [IDLE_W-1:0]     idle_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic [HALF_W-1:0]     half_cnt;
  logic                  sclk_phase;
  logic [FRAME_BITS-1:0] frame;
  logic                  idle_done;
  logic                  half_end;
  logic                  shift_done;
  logic                  sample_edge;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button_debounce (
    .clk        (clk),
    .rst        (rst),
    .button_raw (button_raw),
    .button     (button)
  );

  assign idle_done   = (idle_cnt == IDLE_W'(SAMPLE_INTERVAL - 1));
  assign half_end    = (div_cnt == DIV_W'(SCLK_DIV - 1));
  assign shift_done  = half_end && (half_cnt == HALF_W'(HALF_PERIODS - 1));
  assign sample_edge = (state == ST_SHIFT) && sclk_phase && (div_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (idle_done) next_state = ST_SHIFT;
      ST_SHIFT:  if (shift_done) next_state = ST_UPDATE;
      ST_UPDATE: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    sensor_cs_n = 1'b1;
    sensor_sclk = 1'b0;
    if (state == ST_SHIFT) begin
      sensor_cs_n = 1'b0;
      sensor_sclk = sclk_phase;
    end
  end

  // Counters are only live in their own state so every conversion starts clean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt   <= '0;
      div_cnt    <= '0;
      half_cnt   <= '0;
      sclk_phase <= 1'b0;
      frame      <= '0;
    end else begin
      idle_cnt   <= '0;
      div_cnt    <= '0;
      half_cnt   <= '0;
      sclk_phase <= 1'b0;
      if (state == ST_IDLE && !idle_done) idle_cnt <= idle_cnt + IDLE_W'(1);
      if (state == ST_SHIFT) begin
        if (half_end) begin
          half_cnt   <= half_cnt + HALF_W'(1);
          sclk_phase <= ~sclk_phase;
        end else begin
          div_cnt    <= div_cnt + DIV_W'(1);
          half_cnt   <= half_cnt;
          sclk_phase <= sclk_phase;
        end
      end
      if (sample_edge) frame <= {frame[FRAME_BITS-2:0], sensor_sdo};
    end
  end

  // A set null bit marks the frame malformed and leaves the reading untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      temperature <= '0;
      temp_valid  <= 1'b0;
      sensor_err  <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      if (state == ST_UPDATE) begin
        if (!frame[FRAME_BITS-1]) begin
          temperature <= saturate_temp(frame[7:0]);
          temp_valid  <= 1'b1;
          sensor_err  <= 1'b0;
        end else begin
          sensor_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_smart_home_input.sv
// Self-checking bench for smart_home_input: behavioural sensor, frame table,
// random frames against a reference model, button and reset sequences.
module tb_smart_home_input;

  localparam int DEB = 4;
  localparam int CONV_PERIOD = 64 + 18 * 2 + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       button_raw = 1'b0;
  logic       sensor_sdo = 1'b0;
  logic       sensor_cs_n;
  logic       sensor_sclk;
  logic       button;
  logic [4:0] temperature;
  logic       temp_valid;
  logic       sensor_err;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [8:0] frame;
    int         exp_temp;
    int         exp_err;
    int         exp_valid;
  } vec_t;

  vec_t vecs[11];

  smart_home_input dut (
    .clk         (clk),
    .rst         (rst),
    .button_raw  (button_raw),
    .sensor_sdo  (sensor_sdo),
    .sensor_cs_n (sensor_cs_n),
    .sensor_sclk (sensor_sclk),
    .button      (button),
    .temperature (temperature),
    .temp_valid  (temp_valid),
    .sensor_err  (sensor_err)
  );

  always #5 clk = ~clk;

  // Sensor: presents the frame MSB first, advancing on each falling sclk.
  logic [8:0] next_frame = '0;
  logic [8:0] sent_frame = '0;
  int         bit_idx = 0;
  bit         in_frame = 1'b0;

  always @(negedge sensor_cs_n or posedge sensor_cs_n or negedge sensor_sclk) begin
    if (sensor_cs_n) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      in_frame   = 1'b1;
      sent_frame = next_frame;
      bit_idx    = 8;
      sensor_sdo = sent_frame[8];
    end else if (!sensor_sclk && bit_idx > 0) begin
      bit_idx    = bit_idx - 1;
      sensor_sdo = sent_frame[bit_idx];
    end
  end

  // Bus monitor sampled on the falling clock edge.
  int  cyc = 0;
  int  fall_count = 0;
  int  rise_count = 0;
  int  last_fall = 0;
  int  prev_fall = 0;
  int  cur_low = 0;
  int  low_len_last = 0;
  int  valid_count = 0;
  bit  prev_cs = 1'b1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (prev_cs && !sensor_cs_n) begin
      prev_fall  = last_fall;
      last_fall  = cyc;
      fall_count = fall_count + 1;
      cur_low    = 0;
    end
    if (!sensor_cs_n) cur_low = cur_low + 1;
    if (!prev_cs && sensor_cs_n) begin
      low_len_last = cur_low;
      rise_count   = rise_count + 1;
    end
    if (temp_valid) valid_count = valid_count + 1;
    prev_cs = sensor_cs_n;
  end

  task automatic check_output(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total = total + 1;
    bad = bad + 1;
    $display("[TB] FAIL %s timeout waiting for sensor_cs_n", name);
  endtask

  task automatic run_conversion(input logic [8:0] f, input int exp_t, input int exp_e,
                                input int exp_v, input bit chk_period, input string tag);
    int v0;
    int f0;
    int r0;
    int n;
    next_frame = f;
    v0 = valid_count;
    f0 = fall_count;
    n = 0;
    while (fall_count == f0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (fall_count == f0) begin
      timeout_fail({tag, " fall"});
      return;
    end
    r0 = rise_count;
    n = 0;
    while (rise_count == r0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (rise_count == r0) begin
      timeout_fail({tag, " rise"});
      return;
    end
    repeat (4) @(posedge clk);
    #1;
    check_output({tag, " temperature"}, int'(temperature), exp_t);
    check_output({tag, " sensor_err"}, int'(sensor_err), exp_e);
    check_output({tag, " temp_valid pulses"}, valid_count - v0, exp_v);
    check_output({tag, " cs_n low cycles"}, low_len_last, 36);
    if (chk_period) check_output({tag, " conversion period"}, last_fall - prev_fall, CONV_PERIOD);
  endtask

  task automatic count_button(input int cycles, output int pulses, output int first_at);
    pulses = 0;
    first_at = -1;
    for (int i = 1; i <= cycles; i++) begin
      @(posedge clk);
      #1;
      if (button) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end
    end
  endtask

  initial begin
    int         ref_temp;
    int         ref_err;
    int         pulses;
    int         first_at;
    int         f0;
    int         n;
    logic [8:0] f;

    vecs[0]  = '{9'h016, 22, 0, 1};
    vecs[1]  = '{9'h112, 22, 1, 0};
    vecs[2]  = '{9'h012, 18, 0, 1};
    vecs[3]  = '{9'h050, 31, 0, 1};
    vecs[4]  = '{9'h01F, 31, 0, 1};
    vecs[5]  = '{9'h000, 0,  0, 1};
    vecs[6]  = '{9'h020, 31, 0, 1};
    vecs[7]  = '{9'h000, 0,  0, 1};
    vecs[8]  = '{9'h0FF, 31, 0, 1};
    vecs[9]  = '{9'h1FF, 31, 1, 0};
    vecs[10] = '{9'h005, 5,  0, 1};

    repeat (3) @(negedge clk);
    check_output("reset cs_n", int'(sensor_cs_n), 1);
    check_output("reset sclk", int'(sensor_sclk), 0);
    check_output("reset temperature", int'(temperature), 0);
    check_output("reset temp_valid", int'(temp_valid), 0);
    check_output("reset sensor_err", int'(sensor_err), 0);
    check_output("reset button", int'(button), 0);
    rst = 1'b1;

    // Bouncy press, long hold, release, second press.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      button_raw = ~button_raw;
    end
    @(negedge clk);
    button_raw = 1'b1;
    count_button(100, pulses, first_at);
    check_output("press pulses", pulses, 1);
    check_output("press latency in window", int'(first_at >= 3 && first_at <= 2 + DEB + 1), 1);
    @(negedge clk);
    button_raw = 1'b0;
    count_button(20, pulses, first_at);
    check_output("release pulses", pulses, 0);
    @(negedge clk);
    button_raw = 1'b1;
    count_button(20, pulses, first_at);
    check_output("repress pulses", pulses, 1);

    for (int i = 0; i < 11; i++) begin
      run_conversion(vecs[i].frame, vecs[i].exp_temp, vecs[i].exp_err, vecs[i].exp_valid,
                     i > 0, $sformatf("vec%0d", i));
    end
    ref_temp = 5;
    ref_err = 0;

    for (int i = 0; i < 10; i++) begin
      f[8]   = ($urandom_range(0, 3) == 0);
      f[7:0] = 8'($urandom_range(0, 255));
      if (f[8]) begin
        ref_err = 1;
      end else begin
        ref_temp = (int'(f[7:0]) > 31) ? 31 : int'(f[7:0]);
        ref_err = 0;
      end
      run_conversion(f, ref_temp, ref_err, f[8] ? 0 : 1, 1'b1, $sformatf("rand%0d", i));
    end

    // Reset in the middle of a shift, then time the first conversion after release.
    f0 = fall_count;
    n = 0;
    while (fall_count == f0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (fall_count == f0) timeout_fail("reset shift entry");
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("midshift reset cs_n", int'(sensor_cs_n), 1);
    check_output("midshift reset sclk", int'(sensor_sclk), 0);
    check_output("midshift reset temperature", int'(temperature), 0);
    check_output("midshift reset sensor_err", int'(sensor_err), 0);
    next_frame = 9'h016;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (!sensor_cs_n) begin
        n = i;
        break;
      end
    end
    check_output("cs_n fall after reset release", n, 64);
    repeat (45) @(posedge clk);
    #1;
    check_output("post-reset temperature", int'(temperature), 22);
    check_output("post-reset sensor_err", int'(sensor_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/smart_home_input.md
SMART_HOME_INPUT -- requirements
Module: smart_home_input

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples needed to accept a new button level.
REQ-002 SHALL have parameter SCLK_DIV, default 2: clk cycles per sensor_sclk half-period.
REQ-003 SHALL have parameter SAMPLE_INTERVAL, default 64: clk cycles spent idle between sensor conversions.
REQ-004 SHALL have port clk, input, 1: single clock, all logic rising-edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port button_raw, input, 1: asynchronous, bouncy push-button level.
REQ-007 SHALL have port sensor_sdo, input, 1: serial data from temperature sensor.
REQ-008 SHALL have port sensor_cs_n, output, 1: sensor chip select, active-low.
REQ-009 SHALL have port sensor_sclk, output, 1: sensor serial clock, idles low.
REQ-010 SHALL have port button, output, 1: one-cycle pulse per accepted press; feeds smart-home colour stepper.
REQ-011 SHALL have port temperature, output, 5: last valid temperature in degrees C, unsigned; feeds smart-home heating/cooling control.
REQ-012 SHALL have port temp_valid, output, 1: one-cycle pulse when temperature updates.
REQ-013 SHALL have port sensor_err, output, 1: last frame malformed; sticky until next good frame.

Function
REQ-014 SHALL pass button_raw through a 2-flop synchronizer before any other use.
REQ-015 SHALL update the debounced level only after DEBOUNCE_CYCLES consecutive identical synchronized samples differing from it; any mismatch restarts the count.
REQ-016 SHALL assert button for exactly one cycle on each 0->1 debounced transition; no pulse on release; holding the button indefinitely yields one pulse.
REQ-017 SHALL run a conversion FSM with states IDLE, SHIFT, UPDATE.
REQ-018 IDLE: sensor_cs_n=1, sensor_sclk=0; SHALL stay exactly SAMPLE_INTERVAL cycles, then enter SHIFT.
REQ-019 SHIFT: sensor_cs_n=0; SHALL generate 9 sclk periods, each SCLK_DIV cycles low then SCLK_DIV cycles high (18*SCLK_DIV cycles total), then enter UPDATE.
REQ-020 SHALL sample sensor_sdo in the clk cycle where sensor_sclk goes 0->1, shifting MSB first into a 9-bit frame: bit 8 = null bit, bits 7:0 = unsigned temperature.
REQ-021 UPDATE (one cycle, sensor_cs_n=1): if the null bit is 0, SHALL load temperature = min(data, 31), pulse temp_valid and clear sensor_err.
REQ-022 UPDATE: if the null bit is 1, SHALL set sensor_err, hold temperature, and keep temp_valid low; then return to IDLE.
REQ-023 Saturation SHALL compare the full 8-bit value: data 31 -> 31, 32 -> 31, 255 -> 31, 0 -> 0.
REQ-024 Conversion period SHALL be exactly SAMPLE_INTERVAL + 18*SCLK_DIV + 1 cycles (101 at defaults); button path is independent of the FSM.

Reset
REQ-025 While rst=0, SHALL force: button=0, temperature=0, temp_valid=0, sensor_err=0, sensor_cs_n=1, sensor_sclk=0, FSM=IDLE, all counters and sync/debounce flops to 0.
REQ-026 Reset mid-SHIFT SHALL drop the partial frame; after release the first conversion starts after a full SAMPLE_INTERVAL.

Structure
REQ-027 SHALL take from shared package smart_home_pkg: FSM state enum, TEMP_MAX=31, FRAME_BITS=9, TEMP_W=5.
REQ-028 SHALL instantiate one sub-module, button_debounce (synchronizer, debounce counter, edge pulse), parameterized by DEBOUNCE_CYCLES.

Verification
REQ-029 button_raw toggling every cycle for 6 cycles then held high for 100 cycles -> exactly one button pulse, within 2+DEBOUNCE_CYCLES+1 cycles of settling; release, re-press -> second pulse.
REQ-030 Sensor model returns frame 0_00010110 -> temperature=22, one temp_valid pulse, sensor_cs_n low exactly 36 cycles.
REQ-031 Frame 0_01010000 (80) -> temperature=31, sensor_err=0.
REQ-032 Frame 1_00010010 after temperature=22 -> sensor_err=1, temperature stays 22, no temp_valid; next frame 0_00010010 -> temperature=18, sensor_err=0.
REQ-033 rst driven low during SHIFT -> sensor_cs_n=1, sensor_sclk=0, temperature=0 immediately; next sensor_cs_n fall exactly 64 cycles after rst release.
REQ-034 Free-running conversions -> successive sensor_cs_n falling edges exactly 101 cycles apart.
